// File: rtl/mu0_io_port_if.sv
// mu0_io_port_if: the bus signals around mu0_io_port, grouped by function.
//   CPU side  : address/write/read/writedata/readdata
//   RAM side  : ram_address/ram_write/ram_read/ram_writedata/ram_readdata
//   Out stream: out_data/out_valid/out_ready
//   In stream : in_data/in_valid/in_ready
// The slave modport is the I/O port's view; master is the surrounding system.
interface mu0_io_port_if;
  logic [11:0] address;
  logic        write;
  logic        read;
  logic [15:0] writedata;
  logic [15:0] readdata;

  logic [11:0] ram_address;
  logic        ram_write;
  logic        ram_read;
  logic [15:0] ram_writedata;
  logic [15:0] ram_readdata;

  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;

  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;

  modport slave (
    input  address, write, read, writedata, ram_readdata, out_ready, in_data, in_valid,
    output readdata, ram_address, ram_write, ram_read, ram_writedata, out_data, out_valid,
           in_ready
  );

  modport master (
    output address, write, read, writedata, ram_readdata, out_ready, in_data, in_valid,
    input  readdata, ram_address, ram_write, ram_read, ram_writedata, out_data, out_valid,
           in_ready
  );
endinterface

// File: rtl/mu0_io_port.sv
// mu0_io_port: memory-mapped I/O port between the MU0 CPU and its 4096x16 RAM.
//   OUT_ADDR    : writes are queued in a FIFO and drained on a valid/ready stream.
//   IN_ADDR     : reads return the single-word input holding register.
//   STATUS_ADDR : reads return {count, 4'b0, held, overflow, full, empty};
//                 writes clear the sticky overflow flag.
// All other addresses pass straight through to the RAM.
// Optional feature: define MU0_IO_STATUS_EN to build the status word and the
// overflow flag; without it STATUS_ADDR reads as zero (but is still decoded).
// Reset (rst) is synchronous and active-low.
module mu0_io_port #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [11:0] OUT_ADDR    = 12'hFFE,
  parameter logic [11:0] IN_ADDR     = 12'hFFD,
  parameter logic [11:0] STATUS_ADDR = 12'hFFF
) (
  input  logic          clk,
  input  logic          rst,
  mu0_io_port_if.slave  bus
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   count_t;

  // FIFO state
  logic [15:0] mem_q [FIFO_DEPTH];
  ptr_t        wr_ptr_q, wr_ptr_d;
  ptr_t        rd_ptr_q, rd_ptr_d;
  count_t      count_q,  count_d;

  // Input holding register
  logic [15:0] hold_q,   hold_d;
  logic        held_q,   held_d;

  // Registered read path
  logic        sel_io_q;
  logic [15:0] io_rdata_q, io_rdata_d;

  logic io_hit, empty, full;
  logic push_req, push, pop;
  logic capture, rd_in;

  assign io_hit = (bus.address == OUT_ADDR) || (bus.address == IN_ADDR) ||
                  (bus.address == STATUS_ADDR);

  // RAM passthrough is purely combinational; I/O addresses are masked off.
  assign bus.ram_address   = bus.address;
  assign bus.ram_writedata = bus.writedata;
  assign bus.ram_write     = bus.write & ~io_hit;
  assign bus.ram_read      = bus.read  & ~io_hit;

  assign empty    = (count_q == '0);
  assign full     = (count_q == count_t'(FIFO_DEPTH));
  assign pop      = ~empty & bus.out_ready;
  assign push_req = bus.write & (bus.address == OUT_ADDR);
  // A full FIFO can still take a word when the head leaves on the same edge.
  assign push     = push_req & (~full | pop);

  assign capture  = bus.in_valid & ~held_q;
  assign rd_in    = bus.read & (bus.address == IN_ADDR);

  // Head word comes straight from the array; gated so an empty FIFO shows zero.
  assign bus.out_data  = empty ? 16'h0000 : mem_q[rd_ptr_q];
  assign bus.out_valid = ~empty;
  assign bus.in_ready  = ~held_q;
  assign bus.readdata  = sel_io_q ? io_rdata_q : bus.ram_readdata;

`ifdef MU0_IO_STATUS_EN
  logic        overflow_q;
  logic [15:0] status_w;

  assign status_w = {8'(count_q), 4'b0000, held_q, overflow_q, full, empty};

  // Sticky overflow: set by a dropped push, cleared by any STATUS_ADDR write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      overflow_q <= 1'b0;
    end else if (bus.write && (bus.address == STATUS_ADDR)) begin
      overflow_q <= 1'b0;
    end else if (push_req && !push) begin
      overflow_q <= 1'b1;
    end
  end
`endif

  // Next-state logic for FIFO pointers, input register and read data.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    hold_d     = hold_q;
    held_d     = held_q;
    io_rdata_d = 16'h0000;

    if (push) wr_ptr_d = wr_ptr_q + ptr_t'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + ptr_t'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + count_t'(1);
      2'b01:   count_d = count_q - count_t'(1);
      default: count_d = count_q;
    endcase

    // Capture and read-clear never overlap because in_ready is ~held_q.
    if (capture) begin
      hold_d = bus.in_data;
      held_d = 1'b1;
    end else if (rd_in) begin
      held_d = 1'b0;
    end

    // Read data reflects pre-edge state; OUT_ADDR and unmapped reads give zero.
    if (bus.address == IN_ADDR) begin
      io_rdata_d = held_q ? hold_q : 16'h0000;
    end
`ifdef MU0_IO_STATUS_EN
    else if (bus.address == STATUS_ADDR) begin
      io_rdata_d = status_w;
    end
`endif
  end

  // Control and data registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      hold_q     <= 16'h0000;
      held_q     <= 1'b0;
      sel_io_q   <= 1'b0;
      io_rdata_q <= 16'h0000;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      hold_q     <= hold_d;
      held_q     <= held_d;
      sel_io_q   <= bus.read & io_hit;
      io_rdata_q <= io_rdata_d;
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; count/empty gate every read, so stale words are never visible.
    if (push) mem_q[wr_ptr_q] <= bus.writedata;
  end

endmodule

// File: doc/mu0_io_port.md
# mu0_io_port

Memory-mapped I/O port on the MU0 shared 16-bit bus, inserted between the CPU and the shared 4096x16 RAM. It decodes three reserved addresses at the top of the address space:

- CPU writes to OUT_ADDR are buffered in a FIFO and drained on a valid/ready output stream.
- A single-word input holding register is readable at IN_ADDR.
- A status word is readable at STATUS_ADDR.

All other accesses are forwarded unchanged to the RAM.

## Interface

Parameters:
- FIFO_DEPTH, 8, output FIFO entries; power of 2, range 2..128.
- OUT_ADDR, 12'hFFE, write-only output data address.
- IN_ADDR, 12'hFFD, read-only input data address.
- STATUS_ADDR, 12'hFFF, status read / overflow-clear write address.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset.
- address  input  12  CPU bus address.
- write  input  1  CPU write strobe.
- read  input  1  CPU read strobe.
- writedata  input  16  CPU write data.
- readdata  output  16  data returned to CPU.
- ram_address  output  12  forwarded address (always equals address).
- ram_write  output  1  write & !io_hit.
- ram_read  output  1  read & !io_hit.
- ram_writedata  output  16  forwarded writedata.
- ram_readdata  input  16  RAM read data (one-cycle read latency).
- out_data  output  16  FIFO head word.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  sink accepts head word.
- in_data  input  16  input word.
- in_valid  input  1  input word offered.
- in_ready  output  1  holding register empty.

## Operation

- io_hit is 1 when address is OUT_ADDR, IN_ADDR or STATUS_ADDR. The ram_* outputs are combinational.
- **Push:** occurs when write=1 and address==OUT_ADDR and the FIFO is not full.
  - A push while full is also accepted if a pop occurs on the same edge.
  - Otherwise a push while full is dropped, and overflow is set (sticky).
- **Pop:** occurs when out_valid & out_ready. Simultaneous push and pop leaves count unchanged.
- **Pointers:** wr_ptr and rd_ptr are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. count is log2(FIFO_DEPTH)+1 bits.
- **Input capture:** occurs when in_valid & in_ready; the word is latched into hold_q and held=1.
- **Read of IN_ADDR:** returns hold_q when held, else 16'h0000. It clears held on the same edge. Capture and clear cannot coincide, because in_ready=!held.
- **Status word:** bit0 empty, bit1 full, bit2 overflow, bit3 held, bits[7:4] 0, bits[15:8] count (zero-extended).
- **Write to STATUS_ADDR:** clears overflow; writedata is ignored.
- **Ignored accesses:** writes to IN_ADDR and reads of OUT_ADDR have no effect; a read of OUT_ADDR returns 0.
- **Simultaneous read and write:** both are acted on; the read returns pre-edge state.

## Timing

- **Reset:** while rst=0 at a rising edge:
  - FIFO emptied, overflow=0, held=0, hold_q=0, read-select register=0.
  - Outputs after reset: out_valid=0, out_data=0, in_ready=1, readdata=ram_readdata.
  - Reset mid-operation discards all buffered words.
- **Write latency:** a write at edge N makes the word visible on out_data, with out_valid=1, after edge N if the FIFO was empty.
  - out_data is the head word straight from the storage array, with no extra register.
- **Read latency:** one cycle, matching the RAM.
  - At the read edge, the block registers sel_io_q = read & io_hit and the io read data.
  - In the following cycle, readdata = sel_io_q ? io_rdata_q : ram_readdata.
- **in_ready:** falls the cycle after capture, and rises the cycle after an IN_ADDR read.
- **Status timing:** a status read reflects state before the same-edge push, pop or clear.

## Configuration

- **MU0_IO_STATUS_EN defined:** the status register and overflow flag exist as described above.
- **MU0_IO_STATUS_EN undefined:**
  - STATUS_ADDR reads return 16'h0000 and writes to it are ignored.
  - No overflow register exists; pushes to a full FIFO are still dropped.
  - STATUS_ADDR is still decoded as io_hit, so the RAM never sees it.

## Test plan

- **Reset:** hold rst=0 for 2 cycles -> out_valid=0, in_ready=1, status read = 16'h0001.
- **Stream out:** write 16'h1234 then 16'hBEEF to 12'hFFE with out_ready=0 -> status=16'h0200; assert out_ready -> out_data 16'h1234 then 16'hBEEF on consecutive cycles, then out_valid=0.
- **Overflow:** with out_ready=0, write 9 words (FIFO_DEPTH=8) -> 9th dropped, status=16'h0806. Write to STATUS_ADDR -> status=16'h0802. Push on full with same-edge pop -> accepted, count stays 8.
- **Input:** in_valid=1, in_data=16'h00AA -> in_ready=0 the next cycle. Read 12'hFFD -> readdata=16'h00AA one cycle later and in_ready=1. A second read returns 16'h0000.
- **Passthrough:** write 16'h5555 to 12'h010, then read 12'h010 -> ram_write pulses; readdata=16'h5555. Accesses to 12'hFFD/FFE/FFF never assert ram_read or ram_write.
- **Reset mid-operation:** with 3 words buffered, assert rst=0 for one edge -> out_valid=0 and status count=0 afterwards.
